// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and FSM state type for the segment access controller
package seg_pkg;
    localparam int NSEG  = 8;
    localparam int SEG_W = $clog2(NSEG);
    localparam int OFF_W = 16 - SEG_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;
endpackage

// File: rtl/seg_onehot_dec.sv
// rtl/seg_onehot_dec.sv - combinational segment index to one-hot bank select decoder
module seg_onehot_dec #(
    parameter int  NSEG  = 8,
    localparam int SEG_W = $clog2(NSEG)
) (
    input  logic [SEG_W-1:0] seg_i,
    output logic [NSEG-1:0]  onehot_o
);
    always_comb begin
        onehot_o        = '0;
        onehot_o[seg_i] = 1'b1;
    end
endmodule

// File: rtl/seg_access_ctrl.sv
// rtl/seg_access_ctrl.sv - single-outstanding segmented bank access controller with ack timeout
// Optional SEG_WPROT_EN adds a per-segment write-protect mask port (wprot).
module seg_access_ctrl #(
    parameter int  ADDR_W  = 16,
    parameter int  DATA_W  = 8,
    parameter int  NSEG    = seg_pkg::NSEG,
    parameter int  TIMEOUT = 15,
    localparam int SEG_W   = $clog2(NSEG),
    localparam int OFF_W   = ADDR_W - SEG_W,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [NSEG-1:0]   mem_cs,
    output logic [OFF_W-1:0]  mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef SEG_WPROT_EN
    ,
    input  logic [NSEG-1:0]   wprot
`endif
);
    import seg_pkg::*;

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic [NSEG-1:0]     mem_cs_q, mem_cs_d;
    logic [OFF_W-1:0]    mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [SEG_W-1:0]    req_seg;
    logic [NSEG-1:0]     req_onehot;
    logic                prot_hit;
    logic                timeout_hit;

    assign req_seg     = req_addr[ADDR_W-1 -: SEG_W];
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef SEG_WPROT_EN
    assign prot_hit = req_we & wprot[req_seg];
`else
    assign prot_hit = 1'b0;
`endif

    seg_onehot_dec #(.NSEG(NSEG)) u_dec (
        .seg_i    (req_seg),
        .onehot_o (req_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            mem_cs_q    <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_cs_q    <= mem_cs_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = prot_hit ? S_RESP : S_ACCESS;
            S_ACCESS: if (mem_ack || timeout_hit) state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_d = req_ready_q;
        mem_cs_d    = mem_cs_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    mem_addr_d  = req_addr[OFF_W-1:0];
                    mem_wdata_d = req_wdata;
                    if (prot_hit) begin
                        // Protected write is refused without ever touching the bank.
                        mem_we_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        mem_we_d = req_we;
                        mem_cs_d = req_onehot;
                    end
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack || timeout_hit) begin
                    mem_cs_d    = '0;
                    mem_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !mem_ack;
                    rsp_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign mem_cs    = mem_cs_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
